// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller; break detection compiled in with UART_RX_BREAK_DET_EN
module uart_rx_fsm (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic       PAR_EN,
   input  logic [5:0] Prescale,
   input  logic       sampled_bit,
   input  logic       strt_glitch,
   input  logic       par_err,
   input  logic       stp_err,
   output logic [5:0] edge_cnt,
   output logic [3:0] bit_cnt,
   output logic       dat_samp_en,
   output logic       strt_chk_en,
   output logic       deser_en,
   output logic       par_chk_en,
   output logic       stp_chk_en,
   output logic       data_valid,
   output logic       frame_err,
   output logic       break_det
);
`ifdef UART_RX_BREAK_DET_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif
   state_t     state_q, state_d;
   logic [5:0] edge_q, edge_d, presc_q, presc_d, presc_legal;
   logic [3:0] bit_q, bit_d;
   logic       par_en_q, par_en_d, par_err_q, par_err_d, data_or_q, data_or_d;
   logic       last_edge, chk_edge, data_end, stop_done, frame_ok, line_break, run_d;
   assign presc_legal = (Prescale == 6'd8 || Prescale == 6'd16) ? Prescale : 6'd32;
   assign last_edge   = edge_q == presc_q - 6'd1;
   assign chk_edge    = edge_q == (presc_q >> 1) + 6'd2;
   assign data_end    = state_q == DATA && last_edge && bit_q == 4'd8;
   assign stop_done   = state_q == STOP && last_edge;
   assign frame_ok    = !stp_err && (!par_en_q || !par_err_q);
   assign line_break  = stp_err && !data_or_q;
   assign run_d       = state_d inside {START, DATA, PARITY, STOP};
   assign edge_cnt    = edge_q;
   assign bit_cnt     = bit_q;
   // state and frame bookkeeping registers
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         edge_q    <= 6'd0;
         bit_q     <= 4'd0;
         presc_q   <= 6'd32;
         par_en_q  <= 1'b0;
         par_err_q <= 1'b0;
         data_or_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         edge_q    <= edge_d;
         bit_q     <= bit_d;
         presc_q   <= presc_d;
         par_en_q  <= par_en_d;
         par_err_q <= par_err_d;
         data_or_q <= data_or_d;
      end
   end
   // frame sequencing: each bit ends on the last oversample edge of the latched ratio
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (!RX_IN) state_d = START;
         START:    if (last_edge) state_d = strt_glitch ? IDLE : DATA;
         DATA:     if (data_end) state_d = PAR_EN ? PARITY : STOP;
         PARITY:   if (last_edge) state_d = STOP;
`ifdef UART_RX_BREAK_DET_EN
         STOP:     if (last_edge) state_d = line_break ? BRK_WAIT : IDLE;
         BRK_WAIT: if (RX_IN) state_d = IDLE;
`else
         STOP:     if (last_edge) state_d = IDLE;
`endif
         default:  state_d = IDLE;
      endcase
   end
   // counters park at zero whenever no frame is running; per-frame settings captured once
   always_comb begin
      edge_d    = (!run_d || state_q == IDLE || last_edge) ? 6'd0 : edge_q + 6'd1;
      bit_d     = !run_d ? 4'd0 : (state_q != IDLE && last_edge) ? bit_q + 4'd1 : bit_q;
      presc_d   = (state_q == IDLE && !RX_IN) ? presc_legal : presc_q;
      par_en_d  = state_q == IDLE ? 1'b0 : data_end ? PAR_EN : par_en_q;
      par_err_d = state_q == IDLE ? 1'b0 : (state_q == PARITY && last_edge) ? par_err : par_err_q;
      data_or_d = state_q == IDLE ? 1'b0 : (state_q == DATA && chk_edge) ? data_or_q | sampled_bit : data_or_q;
   end
   // datapath enables and one-cycle frame status pulses
   always_comb begin
      dat_samp_en = state_q inside {START, DATA, PARITY, STOP};
      strt_chk_en = state_q == START && chk_edge;
      deser_en    = state_q == DATA && chk_edge;
      par_chk_en  = state_q == PARITY && chk_edge;
      stp_chk_en  = state_q == STOP && chk_edge;
      data_valid  = stop_done && frame_ok;
`ifdef UART_RX_BREAK_DET_EN
      frame_err   = stop_done && !frame_ok && !line_break;
      break_det   = stop_done && line_break;
`else
      frame_err   = stop_done && (!frame_ok || line_break);
      break_det   = 1'b0;
`endif
   end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames checked against a scoreboard of expected frame outcomes
module tb_uart_rx_fsm;
   localparam logic [2:0] K_DV = 3'b001, K_FE = 3'b010, K_BRK = 3'b100;
   typedef struct { logic [2:0] kind; logic [7:0] data; int len; } exp_t;
   logic       clk = 1'b0, rst = 1'b0, rx = 1'b1, par_en = 1'b0, samp = 1'b1;
   logic       glitch = 1'b0, perr = 1'b0, serr = 1'b0, found = 1'b0, samp_prev = 1'b0;
   logic [5:0] prescale = 6'd8;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
   logic       data_valid, frame_err, break_det;
   logic [17:0] outs;
   logic [7:0] cap = 8'h00;
   exp_t       sb[$];
   exp_t       e;
   int         checks = 0, errors = 0, deser_cnt = 0, samp_cnt = 0;

   uart_rx_fsm dut (
      .CLK(clk), .RST(rst), .RX_IN(rx), .PAR_EN(par_en), .Prescale(prescale),
      .sampled_bit(samp), .strt_glitch(glitch), .par_err(perr), .stp_err(serr),
      .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
      .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
      .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err),
      .break_det(break_det)
   );

   assign outs = {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
                  stp_chk_en, data_valid, frame_err, break_det};

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic b, input int n);
      rx = b;
      samp = b;
      tick(n);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_frame(input logic [2:0] kind, input logic [7:0] d, input int len);
      exp_t x;
      x.kind = kind;
      x.data = d;
      x.len = len;
      sb.push_back(x);
   endtask

   task automatic send_frame(input int bl, input logic [5:0] ps0, input logic [5:0] ps1,
                             input logic [7:0] d, input logic pe, input logic pe_stop,
                             input logic stp);
      prescale = ps0;
      par_en = pe;
      drive(1'b0, bl);
      prescale = ps1;
      for (int i = 0; i < 8; i++) drive(d[i], bl);
      if (pe) drive(^d, bl);
      par_en = pe_stop;
      drive(stp, bl);
   endtask

   always @(negedge clk) begin
      if (strt_chk_en) begin
         deser_cnt = 0;
         cap = 8'h00;
      end
      if (deser_en) begin
         cap = {samp, cap[7:1]};
         deser_cnt++;
      end
      samp_cnt = dat_samp_en ? (samp_prev ? samp_cnt + 1 : 1) : samp_cnt;
      samp_prev = dat_samp_en;
      if (data_valid || frame_err || break_det) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_result got=%b exp=none", {break_det, frame_err, data_valid});
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert ({break_det, frame_err, data_valid} === e.kind) else begin
               errors++;
               $error("FAIL result_kind got=%b exp=%b", {break_det, frame_err, data_valid}, e.kind);
            end
            checks++;
            assert (cap === e.data) else begin
               errors++;
               $error("FAIL deser_data got=%h exp=%h", cap, e.data);
            end
            checks++;
            assert (deser_cnt === 8) else begin
               errors++;
               $error("FAIL deser_pulses got=%0d exp=8", deser_cnt);
            end
            checks++;
            assert (samp_cnt === e.len) else begin
               errors++;
               $error("FAIL frame_cycles got=%0d exp=%0d", samp_cnt, e.len);
            end
         end
      end
   end

   initial begin
      tick(3);
      check("reset_outputs", 32'(outs), 0);
      rst = 1'b1;
      tick(2);
      check("idle_after_reset", 32'(outs), 0);
      expect_frame(K_DV, 8'hA5, 80);
      send_frame(8, 6'd8, 6'd8, 8'hA5, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4);
      perr = 1'b1;
      expect_frame(K_FE, 8'h5A, 176);
      send_frame(16, 6'd16, 6'd16, 8'h5A, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 4);
      check("idle_after_par_err", dat_samp_en, 0);
      perr = 1'b0;
      expect_frame(K_DV, 8'hC3, 176);
      send_frame(16, 6'd16, 6'd16, 8'hC3, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 4);
      par_en = 1'b0;
      glitch = 1'b1;
      prescale = 6'd16;
      drive(1'b0, 3);
      drive(1'b1, 13);
      check("glitch_start_last_edge", {dat_samp_en, edge_cnt}, {1'b1, 6'd15});
      tick(1);
      check("glitch_back_idle", {dat_samp_en, edge_cnt}, 0);
      check("glitch_no_deser", deser_cnt, 0);
      glitch = 1'b0;
      drive(1'b1, 4);
      drive(1'b0, 16);
      rx = 1'b1;
      samp = 1'b1;
      for (int i = 0; i < 200 && !found; i++) begin
         if (bit_cnt == 4'd4) found = 1'b1;
         else tick(1);
      end
      check("reach_bit4", found, 1);
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      check("midframe_reset_outputs", 32'(outs), 0);
      tick(3);
      check("reset_stays_idle", dat_samp_en, 0);
      expect_frame(K_DV, 8'h3C, 80);
      send_frame(8, 6'd8, 6'd8, 8'h3C, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4);
      expect_frame(K_DV, 8'h96, 160);
      send_frame(16, 6'd16, 6'd8, 8'h96, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4);
      expect_frame(K_DV, 8'h69, 80);
      send_frame(8, 6'd8, 6'd8, 8'h69, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4);
      expect_frame(K_DV, 8'h12, 160);
      send_frame(16, 6'd16, 6'd16, 8'h12, 1'b0, 1'b0, 1'b1);
      expect_frame(K_DV, 8'h34, 160);
      send_frame(16, 6'd16, 6'd16, 8'h34, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4);
      expect_frame(K_DV, 8'h81, 320);
      send_frame(32, 6'd12, 6'd12, 8'h81, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4);
      serr = 1'b1;
      expect_frame(K_FE, 8'h01, 80);
      send_frame(8, 6'd8, 6'd8, 8'h01, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4);
`ifdef UART_RX_BREAK_DET_EN
      expect_frame(K_BRK, 8'h00, 80);
      send_frame(8, 6'd8, 6'd8, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 20);
      check("brk_wait_hold", {dat_samp_en, edge_cnt}, 0);
      drive(1'b1, 2);
      check("brk_wait_exit", dat_samp_en, 0);
`else
      expect_frame(K_FE, 8'h00, 80);
      send_frame(8, 6'd8, 6'd8, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4);
`endif
      serr = 1'b0;
      expect_frame(K_DV, 8'hFF, 80);
      send_frame(8, 6'd8, 6'd8, 8'hFF, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 5);
      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all logic on rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port RX_IN, input, 1 bit: serial line, idle high.
REQ-004 SHALL have port PAR_EN, input, 1 bit: parity bit present in frame.
REQ-005 SHALL have port Prescale, input, 6 bits: oversampling ratio; legal values 8, 16, 32.
REQ-006 SHALL have port sampled_bit, input, 1 bit: sampler majority output, valid from edge_cnt = Prescale/2+2.
REQ-007 SHALL have ports strt_glitch, par_err, stp_err, inputs, 1 bit each: checker results, valid one cycle after the matching enable.
REQ-008 SHALL have ports edge_cnt (6 bits) and bit_cnt (4 bits), outputs: oversample edge index and frame bit index.
REQ-009 SHALL have ports dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, outputs, 1 bit each: datapath enables.
REQ-010 SHALL have ports data_valid, frame_err, break_det, outputs, 1 bit each: one-cycle frame status pulses.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-012 SHALL in IDLE, on RX_IN=0, latch Prescale, clear edge_cnt and bit_cnt, and enter START next cycle.
REQ-013 SHALL increment edge_cnt every cycle outside IDLE; at latched Prescale-1, wrap to 0 and increment bit_cnt.
REQ-014 SHALL hold dat_samp_en high in all states except IDLE and BRK_WAIT.
REQ-015 SHALL pulse the current state's enable (strt_chk_en/deser_en/par_chk_en/stp_chk_en) for one cycle at edge_cnt = Prescale/2+2.
REQ-016 SHALL, in START at edge_cnt = Prescale-1, return to IDLE if strt_glitch=1; otherwise enter DATA.
REQ-017 SHALL leave DATA at the last edge of bit_cnt = 8: enter PARITY if PAR_EN=1, else STOP.
REQ-018 SHALL leave PARITY at its last edge and enter STOP.
REQ-019 SHALL at STOP's last edge pulse data_valid if stp_err=0 and (PAR_EN=0 or par_err=0); otherwise pulse frame_err; then enter IDLE.
REQ-020 SHALL use the latched Prescale for the whole frame; mid-frame Prescale changes take effect at the next frame.
REQ-021 SHALL sample PAR_EN at the DATA exit decision only.
REQ-022 SHALL, on RX_IN=0 in the same cycle as STOP exit, enter IDLE first; the start bit is detected on the following cycle.
REQ-023 SHALL never assert data_valid and frame_err in the same cycle.
REQ-024 SHALL treat an illegal Prescale as 32.

Reset
REQ-025 SHALL, when RST=0 at a rising CLK edge, enter IDLE and zero edge_cnt, bit_cnt and all enable and status outputs; this applies in any state, including mid-frame.
REQ-026 SHALL, after reset release, require a fresh RX_IN falling level before a frame starts.

Configuration
REQ-027 SHALL compile break detection only when macro UART_RX_BREAK_DET_EN is defined.
REQ-028 SHALL, with UART_RX_BREAK_DET_EN defined, track the OR of data-bit sampled_bit values; at STOP exit with all data bits 0 and stp_err=1, pulse break_det instead of frame_err and enter BRK_WAIT; BRK_WAIT exits to IDLE when RX_IN=1.
REQ-029 SHALL, without UART_RX_BREAK_DET_EN, tie break_det to 0, omit BRK_WAIT, and report breaks as frame_err.

Verification
REQ-030 SHALL cover: Prescale=8, PAR_EN=0, byte 0xA5, good stop -> deser_en pulses 8 times, data_valid one cycle at frame end, frame_err=0.
REQ-031 SHALL cover: Prescale=16, PAR_EN=1, par_err=1 after par_chk_en -> frame_err one cycle, data_valid=0, return to IDLE.
REQ-032 SHALL cover: RX_IN low for 3 cycles only, strt_glitch=1 -> FSM returns to IDLE after 16 cycles, no deser_en pulse.
REQ-033 SHALL cover: RST=0 during DATA with bit_cnt=4 -> next cycle IDLE, all outputs 0; next frame 0x3C received correctly.
REQ-034 SHALL cover: Prescale changed 16->8 mid-frame -> current frame still uses 16 cycles per bit; next frame uses 8.
REQ-035 SHALL cover: data 0x00 with stop=0 -> break_det=1 and BRK_WAIT held until RX_IN=1 with UART_RX_BREAK_DET_EN defined; frame_err=1 without it.
